timer_entry_loader: RTL and testbench

//  Keypad-side writer for the microwave MM:SS countdown timer. Collects BCD

---
 rtl/timer_entry_loader_if.sv | 50 +++++
 rtl/timer_entry_loader.sv | 167 ++++++++++++++++
 tb/tb_timer_entry_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_entry_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_entry_loader_if
//  Description : Keypad / countdown-counter bundle for the microwave timer
//                entry loader.
//                  key_valid, key_code  - keypad decoder strobe and code
//                  timer_zero           - counter chain reads 00:00
//                  entry_digits         - entry register, for the display
//                  load, load_digits    - parallel load into digit counters
//                  run_en, done, err    - run enable and status pulses
//                The master modport is the keypad/counter side and the slave
//                modport is the loader itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_entry_loader_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        timer_zero;
    logic [15:0] entry_digits;
    logic        load;
    logic [15:0] load_digits;
    logic        run_en;
    logic        done;
    logic        err;

    modport master (
        output key_valid,
        output key_code,
        output timer_zero,
        input  entry_digits,
        input  load,
        input  load_digits,
        input  run_en,
        input  done,
        input  err
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  timer_zero,
        output entry_digits,
        output load,
        output load_digits,
        output run_en,
        output done,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/timer_entry_loader.sv
`default_nettype none
// ============================================================================
//  Module      : timer_entry_loader
//  Description : Keypad-side writer for the MM:SS countdown timer. Shifts BCD
//                digits into a 4-digit entry register, validates the entry on
//                START, issues a one-cycle parallel load into the digit
//                counters, then holds run_en until the counter chain reports
//                zero or the CLEAR/STOP key is pressed.
//  Ports       : clk   - system clock, rising edge
//                clear - synchronous active-high reset
//                bus   - timer_entry_loader_if.slave (keys, timer_zero,
//                        entry_digits, load, load_digits, run_en, done, err)
//  Parameters  : MAX_SEC_TENS   - largest accepted seconds-tens digit
//                QUICK_SEC_TENS - seconds-tens loaded by START on empty entry
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_entry_loader #(
    parameter int unsigned MAX_SEC_TENS   = 5,
    parameter int unsigned QUICK_SEC_TENS = 3
) (
    input  wire logic          clk,
    input  wire logic          clear,
    timer_entry_loader_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_KEY_MAX_DIGIT = 4'h9;
    localparam logic [3:0] c_KEY_START     = 4'hA;
    localparam logic [3:0] c_KEY_STOP      = 4'hB;

    localparam logic [3:0] c_MAX_SEC_TENS   = 4'(MAX_SEC_TENS);
    localparam logic [3:0] c_QUICK_SEC_TENS = 4'(QUICK_SEC_TENS);

    localparam logic [2:0] c_FULL_COUNT = 3'd4;

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ENTRY = 2'd1;
    localparam logic [1:0] c_ST_LOAD  = 2'd2;
    localparam logic [1:0] c_ST_RUN   = 2'd3;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [15:0] r_entry;
    logic [2:0]  r_count;
    logic        r_load;
    logic [15:0] r_load_digits;
    logic        r_run_en;
    logic        r_done;
    logic        r_err;

    // ------------------------------------------------------------------------
    // Key decode (codes C-F decode to nothing and are therefore inert)
    // ------------------------------------------------------------------------
    logic w_key_digit;
    logic w_key_start;
    logic w_key_stop;
    logic w_sec_tens_bad;

    assign w_key_digit    = bus.key_valid && (bus.key_code <= c_KEY_MAX_DIGIT);
    assign w_key_start    = bus.key_valid && (bus.key_code == c_KEY_START);
    assign w_key_stop     = bus.key_valid && (bus.key_code == c_KEY_STOP);
    // Seconds-tens sits in nibble [7:4] of {min_tens,min_ones,sec_tens,sec_ones}
    assign w_sec_tens_bad = (r_entry[7:4] > c_MAX_SEC_TENS);

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state       <= c_ST_EMPTY;
            r_entry       <= 16'h0000;
            r_count       <= 3'd0;
            r_load        <= 1'b0;
            r_load_digits <= 16'h0000;
            r_run_en      <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // Pulse outputs are high for exactly one cycle
            r_load <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                c_ST_EMPTY, c_ST_ENTRY: begin
                    if (w_key_stop) begin
                        r_state <= c_ST_EMPTY;
                        r_entry <= 16'h0000;
                        r_count <= 3'd0;
                    end else if (w_key_digit) begin
                        // Once four digits are held, further digits are dropped
                        if (r_count < c_FULL_COUNT) begin
                            r_entry <= {r_entry[11:0], bus.key_code};
                            r_count <= r_count + 3'd1;
                        end
                        r_state <= c_ST_ENTRY;
                    end else if (w_key_start) begin
                        if (r_state == c_ST_EMPTY) begin
                            // Quick start: 00:30 style preset
                            r_load_digits <= {4'h0, 4'h0, c_QUICK_SEC_TENS, 4'h0};
                            r_load        <= 1'b1;
                            r_state       <= c_ST_LOAD;
                        end else if (w_sec_tens_bad) begin
                            // Entry is kept so the user can see what was rejected
                            r_err <= 1'b1;
                        end else begin
                            r_load_digits <= r_entry;
                            r_load        <= 1'b1;
                            r_state       <= c_ST_LOAD;
                        end
                    end
                end

                c_ST_LOAD: begin
                    // timer_zero is deliberately not looked at here: the
                    // counters only capture the new value on this edge.
                    if (w_key_stop) begin
                        r_state  <= c_ST_EMPTY;
                        r_entry  <= 16'h0000;
                        r_count  <= 3'd0;
                        r_run_en <= 1'b0;
                    end else begin
                        r_run_en <= 1'b1;
                        r_state  <= c_ST_RUN;
                    end
                end

                c_ST_RUN: begin
                    // STOP takes priority over a coincident zero: no done pulse
                    if (w_key_stop) begin
                        r_state  <= c_ST_EMPTY;
                        r_entry  <= 16'h0000;
                        r_count  <= 3'd0;
                        r_run_en <= 1'b0;
                    end else if (bus.timer_zero) begin
                        r_done   <= 1'b1;
                        r_run_en <= 1'b0;
                        r_entry  <= 16'h0000;
                        r_count  <= 3'd0;
                        r_state  <= c_ST_EMPTY;
                    end
                end

                default: begin
                    r_state  <= c_ST_EMPTY;
                    r_run_en <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.entry_digits = r_entry;
    assign bus.load         = r_load;
    assign bus.load_digits  = r_load_digits;
    assign bus.run_en       = r_run_en;
    assign bus.done         = r_done;
    assign bus.err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_timer_entry_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_entry_loader
//  Description : Self-checking bench for timer_entry_loader. Directed key
//                sequences followed by random keypad traffic; a queue-based
//                reference model predicts every cycle's outputs and a
//                separate monitor compares them against the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_entry_loader;

    localparam int c_MAX_SEC_TENS   = 5;
    localparam int c_QUICK_SEC_TENS = 3;

    typedef struct packed {
        logic        load;
        logic        run_en;
        logic        done;
        logic        err;
        logic [15:0] entry;
        logic [15:0] ld;
    } exp_t;

    logic clk;
    logic clear;

    timer_entry_loader_if bus ();

    timer_entry_loader #(
        .MAX_SEC_TENS   (c_MAX_SEC_TENS),
        .QUICK_SEC_TENS (c_QUICK_SEC_TENS)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------------
    exp_t q_exp[$];
    int   tests_run  = 0;
    int   tests_fail = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests_run++;
        if (act !== req) begin
            tests_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: entered digits kept as a plain list, activity as two
    // flags (a load is in flight / the timer is running).
    // ------------------------------------------------------------------------
    int          m_digits[$];
    bit          m_loading;
    bit          m_running;
    logic [15:0] m_ld;

    function automatic logic [15:0] m_entry_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return 16'(v);
    endfunction

    function automatic int m_sec_tens();
        if (m_digits.size() >= 2) return m_digits[m_digits.size() - 2];
        return 0;
    endfunction

    function automatic exp_t model_step(input bit c, input bit kv, input logic [3:0] kc, input bit tz);
        exp_t e;
        e.load = 1'b0; e.done = 1'b0; e.err = 1'b0;
        if (c) begin
            m_digits.delete();
            m_loading = 1'b0;
            m_running = 1'b0;
            m_ld      = 16'h0000;
        end else if (m_loading) begin
            m_loading = 1'b0;
            if (kv && kc == 4'hB) m_digits.delete();
            else                  m_running = 1'b1;
        end else if (m_running) begin
            if (kv && kc == 4'hB) begin
                m_digits.delete();
                m_running = 1'b0;
            end else if (tz) begin
                e.done = 1'b1;
                m_digits.delete();
                m_running = 1'b0;
            end
        end else if (kv) begin
            if (kc <= 4'd9) begin
                if (m_digits.size() < 4) m_digits.push_back(int'(kc));
            end else if (kc == 4'hA) begin
                if (m_digits.size() == 0) begin
                    m_ld      = 16'(c_QUICK_SEC_TENS * 16);
                    m_loading = 1'b1;
                    e.load    = 1'b1;
                end else if (m_sec_tens() > c_MAX_SEC_TENS) begin
                    e.err = 1'b1;
                end else begin
                    m_ld      = m_entry_value();
                    m_loading = 1'b1;
                    e.load    = 1'b1;
                end
            end else if (kc == 4'hB) begin
                m_digits.delete();
            end
        end
        e.run_en = m_running;
        e.entry  = m_entry_value();
        e.ld     = m_ld;
        return e;
    endfunction

    // One cycle of stimulus: inputs change on the falling edge, the model
    // predicts what the next rising edge will produce.
    task automatic drive(input bit c, input bit kv, input logic [3:0] kc, input bit tz);
        @(negedge clk);
        clear          = c;
        bus.key_valid  = kv;
        bus.key_code   = kc;
        bus.timer_zero = tz;
        q_exp.push_back(model_step(c, kv, kc, tz));
    endtask

    task automatic key(input logic [3:0] kc);
        drive(1'b0, 1'b1, kc, 1'b0);
    endtask

    task automatic idle(input int n, input bit tz);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, tz);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: sample just after each rising edge
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check("load",         16'(bus.load),   16'(e.load));
                check("run_en",       16'(bus.run_en), 16'(e.run_en));
                check("done",         16'(bus.done),   16'(e.done));
                check("err",          16'(bus.err),    16'(e.err));
                check("entry_digits", bus.entry_digits, e.entry);
                check("load_digits",  bus.load_digits,  e.ld);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int guard;
        clear          = 1'b1;
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'h0;
        bus.timer_zero = 1'b0;
        m_loading      = 1'b0;
        m_running      = 1'b0;
        m_ld           = 16'h0000;

        // T1: reset, four digits, fifth digit ignored
        drive(1'b1, 1'b0, 4'h0, 1'b0);
        drive(1'b1, 1'b0, 4'h0, 1'b0);
        key(4'h1); key(4'h2); key(4'h3); key(4'h0);
        key(4'h7);
        idle(1, 1'b0);

        // T2: rejected START (seconds-tens 9)
        key(4'hB);
        key(4'h9); key(4'h0); key(4'hA);
        idle(3, 1'b0);

        // T3: quick start from empty
        drive(1'b1, 1'b0, 4'h0, 1'b0);
        key(4'hA);
        idle(3, 1'b0);
        key(4'hB);

        // T4: timer_zero during LOAD is ignored, honoured in RUN
        key(4'h4); key(4'h5); key(4'hA);
        idle(1, 1'b1);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // T5: CLEAR and timer_zero together in RUN
        key(4'h1); key(4'h2); key(4'hA);
        idle(3, 1'b0);
        drive(1'b0, 1'b1, 4'hB, 1'b1);
        idle(2, 1'b0);

        // T6: reset during LOAD; ignored codes in ENTRY
        key(4'h2); key(4'h0); key(4'hA);
        drive(1'b1, 1'b0, 4'h0, 1'b0);
        idle(3, 1'b0);
        key(4'h3); key(4'hE); key(4'hC); key(4'hF); key(4'hD);
        idle(1, 1'b0);

        // Boundary: seconds-tens exactly at the limit, and just above it
        key(4'hB); key(4'h5); key(4'h9); key(4'hA);
        idle(2, 1'b0); key(4'hB);
        key(4'h6); key(4'h0); key(4'hA);
        idle(2, 1'b0); key(4'hB);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit          c, kv, tz;
            logic [3:0]  kc;
            int          k;
            c  = ($urandom_range(0, 149) == 0);
            kv = ($urandom_range(0, 2) != 0);
            tz = ($urandom_range(0, 7) == 0);
            k  = $urandom_range(0, 19);
            if (k < 10)      kc = 4'(k);
            else if (k < 14) kc = 4'hA;
            else if (k < 16) kc = 4'hB;
            else             kc = 4'(k - 4);
            drive(c, kv, kc, tz);
        end
        idle(3, 1'b0);

        // Drain the scoreboard within a bounded number of cycles
        guard = 0;
        while (q_exp.size() != 0 && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (q_exp.size() != 0) begin
            tests_run++;
            tests_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
`default_nettype wire
